// File: rtl/l1602a_pkg.sv
// l1602a_pkg: op encodings, frame geometry and FSM states shared by the frame writer and the LCD controller.
package l1602a_pkg;
  localparam logic [3:0] OP_INIT = 4'b0001;
  localparam logic [3:0] OP_WRITE = 4'b0010;
  localparam logic [3:0] OP_CLEAR = 4'b0100;
  localparam logic [7:0] PAD_CHAR = 8'h20;
  localparam int LINE_LEN = 16;
  localparam int GAP_LEN = 24;
  localparam int FRAME_STEPS = 57;
  typedef enum logic [2:0] {S_INIT_ISSUE, S_INIT_WAIT, S_IDLE, S_ISSUE, S_WAIT} state_e;
  // Buffer index for a WRITE step: line 1 follows CLEAR, line 2 follows the DDRAM gap.
  function automatic logic [4:0] step_addr(input logic [5:0] step);
    logic [5:0] s;
    s = step - 6'd1;
    return (s < 6'(LINE_LEN)) ? s[4:0] : 5'(s - 6'(GAP_LEN));
  endfunction
endpackage

// File: rtl/l1602a_frame_writer_buf.sv
// lcd_frame_buffer: 32x8 character store, one synchronous write port, one combinational read port.
module lcd_frame_buffer
  import l1602a_pkg::*;
#(
  parameter logic [7:0] PAD = l1602a_pkg::PAD_CHAR
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] raddr_i,
  output logic [7:0] rdata_o
);
  logic [7:0] mem_q [32];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mem_q <= '{default: PAD};
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/l1602a_frame_writer.sv
// l1602a_frame_writer: issues INIT once, then on refresh streams CLEAR plus 56 WRITEs of the frame to the LCD controller.
module l1602a_frame_writer
  import l1602a_pkg::*;
#(
  parameter int NCOMMANDS = 3,
  parameter logic [7:0] PAD_CHAR = l1602a_pkg::PAD_CHAR
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [4:0]           wr_addr_i,
  input  logic [7:0]           wr_data_i,
  input  logic                 refresh_i,
  input  logic                 lcd_rdy_i,
  output logic [NCOMMANDS:0]   op_out_o,
  output logic [7:0]           data_out_o,
  output logic                 lcd_en_o,
  output logic                 busy_o,
  output logic                 done_o
);
  localparam logic [5:0] LAST = 6'(FRAME_STEPS - 1);
  state_e state_q, state_d;
  logic [5:0] step_q, step_d;
  logic [NCOMMANDS:0] op_q, op_d, issue_op;
  logic [7:0] data_q, data_d, issue_data, rd_data;
  logic en_q, en_d, done_q, done_d, busy_q, pend_q, pend_d, fell_q, fell_d, gap;
  lcd_frame_buffer #(.PAD(PAD_CHAR)) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (wr_en_i),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .raddr_i (step_addr(step_q)),
    .rdata_o (rd_data)
  );
  assign gap = (step_q > 6'(LINE_LEN)) && (step_q <= 6'(LINE_LEN + GAP_LEN));
  assign issue_op = (step_q == '0) ? (NCOMMANDS+1)'(OP_CLEAR) : (NCOMMANDS+1)'(OP_WRITE);
  assign issue_data = (step_q == '0) ? 8'h00 : gap ? PAD_CHAR : rd_data;
  // fell tracks whether lcd_rdy has dropped since the last issue, so a wait ends only on a full low-high cycle.
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    pend_d = pend_q | (refresh_i & (state_q != S_IDLE));
    fell_d = fell_q | ~lcd_rdy_i;
    en_d = 1'b0;
    done_d = 1'b0;
    op_d = op_q;
    data_d = data_q;
    case (state_q)
      S_INIT_ISSUE: if (lcd_rdy_i) begin
        en_d = 1'b1;
        op_d = (NCOMMANDS+1)'(OP_INIT);
        data_d = 8'h00;
        fell_d = 1'b0;
        state_d = S_INIT_WAIT;
      end
      S_INIT_WAIT: if (lcd_rdy_i && fell_q) state_d = S_IDLE;
      S_IDLE: if (pend_q || refresh_i) begin
        pend_d = 1'b0;
        step_d = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: if (lcd_rdy_i) begin
        en_d = 1'b1;
        op_d = issue_op;
        data_d = issue_data;
        fell_d = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: if (lcd_rdy_i && fell_q) begin
        done_d = (step_q == LAST);
        state_d = done_d ? S_IDLE : S_ISSUE;
        step_d = done_d ? step_q : step_q + 6'd1;
      end
      default: state_d = S_INIT_ISSUE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT_ISSUE;
      step_q <= '0;
      pend_q <= 1'b0;
      fell_q <= 1'b0;
      en_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      op_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      pend_q <= pend_d;
      fell_q <= fell_d;
      en_q <= en_d;
      done_q <= done_d;
      busy_q <= (state_d != S_IDLE);
      op_q <= op_d;
      data_q <= data_d;
    end
  end
  assign op_out_o = op_q;
  assign data_out_o = data_q;
  assign lcd_en_o = en_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_l1602a_frame_writer.sv
// tb_l1602a_frame_writer: drives the frame writer against a ready/busy controller model and checks every issued op.
module tb_l1602a_frame_writer;
  logic clk = 1'b0, rst_ni = 1'b0, wr_en = 1'b0, refresh = 1'b0, stall = 1'b0, rdy_m = 1'b1;
  logic lcd_rdy, lcd_en, busy, done;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0, data;
  logic [3:0] op;
  int checks = 0, errors = 0, cnt = 0, fixed_lat = 0, done_cnt = 0;
  logic [11:0] ops[$], exp_q[$];
  logic [7:0] ref_buf [32];

  assign lcd_rdy = rdy_m & ~stall;
  always #5 clk = ~clk;

  l1602a_frame_writer dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .refresh_i  (refresh),
    .lcd_rdy_i  (lcd_rdy),
    .op_out_o   (op),
    .data_out_o (data),
    .lcd_en_o   (lcd_en),
    .busy_o     (busy),
    .done_o     (done)
  );

  // Monitor: log every issued op and every done pulse.
  always begin
    @(posedge clk); #1;
    if (lcd_en) ops.push_back({op, data});
    if (done) done_cnt++;
  end

  // Controller model: ready drops for a few cycles after each enable.
  always begin
    @(posedge clk); #2;
    if (!rst_ni) begin cnt = 0; rdy_m = 1'b1; end
    else if (lcd_en) begin cnt = fixed_lat > 0 ? fixed_lat : int'($urandom_range(1, 10)); rdy_m = 1'b0; end
    else if (cnt > 0) begin cnt--; rdy_m = (cnt == 0); end
  end

  // Expected frame: CLEAR, line 1, the 24-char DDRAM gap, line 2.
  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back({4'b0100, 8'h00});
    for (int a = 0; a < 16; a++) exp_q.push_back({4'b0010, ref_buf[a]});
    repeat (24) exp_q.push_back({4'b0010, 8'h20});
    for (int a = 16; a < 32; a++) exp_q.push_back({4'b0010, ref_buf[a]});
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; wr_en = 1'b0; refresh = 1'b0; stall = 1'b0;
    foreach (ref_buf[i]) ref_buf[i] = 8'h20;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_and_init(output bit ok);
    ops.delete();
    rst_ni = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ops.size() >= 1 && !busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic write_buf(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    ref_buf[a] = d;
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    int s = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 4000 * n; i++) begin
      if (done_cnt >= s + n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_ops(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (ops.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    checks += 5;
    if (op !== 4'd0) begin errors++; $display("FAIL rst_op: got %h expected 0", op); end
    if (data !== 8'd0) begin errors++; $display("FAIL rst_data: got %h expected 0", data); end
    if (lcd_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b expected 0", lcd_en); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    fixed_lat = 10;
    release_and_init(ok);
    repeat (30) @(negedge clk);
    checks += 5;
    if (!ok) begin errors++; $display("FAIL init_timeout: got no idle, expected idle after INIT"); end
    if (ops.size() != 1) begin errors++; $display("FAIL init_count: got %0d ops expected 1", ops.size()); end
    if (ops.size() == 0 || ops[0][11:8] !== 4'b0001) begin errors++; $display("FAIL init_op: got %h expected op 0001", ops.size() ? ops[0] : 12'hxxx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL init_busy: got %b expected 0", busy); end
    if (done_cnt != 0) begin errors++; $display("FAIL init_done: got %0d pulses expected 0", done_cnt); end
    fixed_lat = 0;
  endtask

  task automatic test_hello();
    bit ok;
    int d0;
    logic [7:0] msg [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    for (int i = 0; i < 5; i++) write_buf(5'(i), msg[i]);
    ops.delete();
    d0 = done_cnt;
    pulse_refresh();
    wait_done(1, ok);
    repeat (20) @(negedge clk);
    build_exp();
    checks += 3;
    if (!ok) begin errors++; $display("FAIL hello_timeout: got no done, expected done"); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL hello_done: got %0d pulses expected 1", done_cnt - d0); end
    if (ops.size() != exp_q.size()) begin errors++; $display("FAIL hello_len: got %0d ops expected %0d", ops.size(), exp_q.size()); end
    else foreach (exp_q[i]) if (ops[i] !== exp_q[i]) begin errors++; $display("FAIL hello_op[%0d]: got %h expected %h", i, ops[i], exp_q[i]); break; end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 3; it++) begin
      repeat ($urandom_range(1, 8)) write_buf(5'($urandom_range(0, 31)), 8'($urandom_range(33, 126)));
      ops.delete();
      pulse_refresh();
      wait_done(1, ok);
      build_exp();
      checks++;
      if (!ok || ops.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_len: got %0d ops expected %0d", it, ops.size(), exp_q.size()); end
      else foreach (exp_q[i]) if (ops[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_op[%0d]: got %h expected %h", it, i, ops[i], exp_q[i]); break; end
    end
  endtask

  task automatic test_line2();
    bit ok;
    write_buf(5'd16, 8'h5A);
    ops.delete();
    pulse_refresh();
    wait_done(1, ok);
    build_exp();
    checks += 2;
    if (ops.size() < 42 || ops[41] !== {4'b0010, 8'h5A}) begin errors++; $display("FAIL line2_step41: got %h expected 25a", ops.size() > 41 ? ops[41] : 12'hxxx); end
    if (!ok || ops.size() != exp_q.size()) begin errors++; $display("FAIL line2_len: got %0d ops expected %0d", ops.size(), exp_q.size()); end
    else foreach (exp_q[i]) if (ops[i] !== exp_q[i]) begin errors++; $display("FAIL line2_op[%0d]: got %h expected %h", i, ops[i], exp_q[i]); break; end
  endtask

  task automatic test_collision();
    bit ok;
    logic [7:0] nv;
    nv = ref_buf[4] ^ 8'h40;
    build_exp();
    ops.delete();
    pulse_refresh();
    wait_ops(5, ok);
    for (int i = 0; i < 100 && !lcd_rdy; i++) @(negedge clk);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = nv;
    @(negedge clk);
    wr_en = 1'b0;
    checks += 2;
    if (ops.size() != 6) begin errors++; $display("FAIL coll_issue_time: got %0d ops expected 6", ops.size()); end
    if (ops.size() < 6 || ops[5] !== exp_q[5]) begin errors++; $display("FAIL coll_old_data: got %h expected %h", ops.size() > 5 ? ops[5] : 12'hxxx, exp_q[5]); end
    wait_done(1, ok);
    ref_buf[4] = nv;
    checks++;
    if (!ok || ops.size() != exp_q.size()) begin errors++; $display("FAIL coll_len: got %0d ops expected %0d", ops.size(), exp_q.size()); end
    else foreach (exp_q[i]) if (ops[i] !== exp_q[i]) begin errors++; $display("FAIL coll_op[%0d]: got %h expected %h", i, ops[i], exp_q[i]); break; end
    build_exp();
    ops.delete();
    pulse_refresh();
    wait_done(1, ok);
    checks++;
    if (!ok || ops.size() != exp_q.size()) begin errors++; $display("FAIL coll_next_len: got %0d ops expected %0d", ops.size(), exp_q.size()); end
    else foreach (exp_q[i]) if (ops[i] !== exp_q[i]) begin errors++; $display("FAIL coll_next_op[%0d]: got %h expected %h", i, ops[i], exp_q[i]); break; end
  endtask

  task automatic test_pending();
    bit ok;
    int d0;
    do_reset();
    fixed_lat = 10;
    ops.delete();
    rst_ni = 1'b1;
    wait_ops(1, ok);
    pulse_refresh();
    pulse_refresh();
    fixed_lat = 0;
    wait_ops(11, ok);
    d0 = done_cnt;
    pulse_refresh();
    pulse_refresh();
    wait_done(2, ok);
    repeat (100) @(negedge clk);
    build_exp();
    checks += 3;
    if (!ok) begin errors++; $display("FAIL pend_timeout: got no done, expected 2 frames"); end
    if (done_cnt - d0 != 2) begin errors++; $display("FAIL pend_done: got %0d pulses expected 2", done_cnt - d0); end
    if (ops.size() != 1 + 2 * 57) begin errors++; $display("FAIL pend_len: got %0d ops expected 115", ops.size()); end
    else for (int f = 0; f < 2; f++) begin
      checks++;
      foreach (exp_q[i]) if (ops[1 + 57 * f + i] !== exp_q[i]) begin errors++; $display("FAIL pend_f%0d_op[%0d]: got %h expected %h", f, i, ops[1 + 57 * f + i], exp_q[i]); break; end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    write_buf(5'd0, 8'h41);
    ops.delete();
    pulse_refresh();
    wait_ops(21, ok);
    d0 = done_cnt;
    rst_ni = 1'b0;
    #1;
    checks += 2;
    if (lcd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl: got en=%b busy=%b done=%b expected 0", lcd_en, busy, done); end
    if (op !== 4'd0 || data !== 8'd0) begin errors++; $display("FAIL mid_rst_bus: got op=%h data=%h expected 0", op, data); end
    do_reset();
    release_and_init(ok);
    checks += 2;
    if (done_cnt != d0) begin errors++; $display("FAIL mid_done: got %0d pulses expected 0", done_cnt - d0); end
    if (!ok || ops.size() != 1 || ops[0][11:8] !== 4'b0001) begin errors++; $display("FAIL mid_reinit: got %0d ops expected one INIT", ops.size()); end
    ops.delete();
    pulse_refresh();
    wait_done(1, ok);
    build_exp();
    checks++;
    if (!ok || ops.size() != exp_q.size()) begin errors++; $display("FAIL mid_len: got %0d ops expected %0d", ops.size(), exp_q.size()); end
    else foreach (exp_q[i]) if (ops[i] !== exp_q[i]) begin errors++; $display("FAIL mid_op[%0d]: got %h expected %h", i, ops[i], exp_q[i]); break; end
  endtask

  task automatic test_stall();
    bit ok;
    write_buf(5'd31, 8'h21);
    ops.delete();
    stall = 1'b1;
    pulse_refresh();
    repeat (1000) @(negedge clk);
    checks += 3;
    if (ops.size() != 0) begin errors++; $display("FAIL stall_en: got %0d ops expected 0", ops.size()); end
    if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1", busy); end
    if (lcd_en !== 1'b0) begin errors++; $display("FAIL stall_pre: got %b expected 0", lcd_en); end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (lcd_en !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", lcd_en); end
    wait_done(1, ok);
    build_exp();
    checks++;
    if (!ok || ops.size() != exp_q.size()) begin errors++; $display("FAIL stall_len: got %0d ops expected %0d", ops.size(), exp_q.size()); end
    else foreach (exp_q[i]) if (ops[i] !== exp_q[i]) begin errors++; $display("FAIL stall_op[%0d]: got %h expected %h", i, ops[i], exp_q[i]); break; end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_random();
    test_line2();
    test_collision();
    test_pending();
    test_reset_mid();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
